// File: rtl/dp_run_pkg.sv
// Shared types for the datapath run controller: the run-state encoding and helpers.
package dp_run_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } run_state_e;

  function automatic logic state_is_busy(input run_state_e s);
    return (s == ST_RESET) || (s == ST_RUN) || (s == ST_STEP);
  endfunction

  function automatic logic state_holds_dp_rst(input run_state_e s);
    return (s == ST_IDLE) || (s == ST_RESET);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// One-cycle pulse on each 0->1 transition of d; history clears on reset.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/dp_run_controller.sv
// Run controller for the single-cycle datapath: reset sequencing, free-run or
// single-step clock enable, executed-cycle counting, halt/abort/timeout stop.
module dp_run_controller
  import dp_run_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic              step,
  input  logic [ADDR_W-1:0] halt_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic              dp_rst,
  output logic              dp_en,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycle_cnt,
  output run_state_e        dbg_state
);

  localparam int              RST_W       = $clog2(RST_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LAST   = RST_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic             TIMEOUT_ON  = (TIMEOUT != 0);

  run_state_e       state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             mode_q, mode_d;
  logic             dp_rst_q, dp_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timed_out_q, timed_out_d;

  logic             step_rise;
  logic             halt_hit;
  logic             exec_slot;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  rise_detect u_step_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (step),
    .rise (step_rise)
  );

  // halt_addr is compared live; the instruction at the halt PC is never executed.
  assign halt_hit  = (pc == halt_addr);
  assign exec_slot = (state_q == ST_RUN) || ((state_q == ST_STEP) && step_rise);
  assign dp_en     = exec_slot && !halt_hit && !abort && !rst;

  assign cnt_inc     = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
  assign timeout_hit = TIMEOUT_ON && dp_en && (cnt_inc == TIMEOUT_CNT);

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    mode_d      = mode_q;
    timed_out_d = timed_out_q;

    if (dp_en) begin
      cycle_cnt_d = cnt_inc;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // start outranks abort here; abort has no effect outside a run.
        if (start) begin
          state_d     = ST_RESET;
          rst_cnt_d   = '0;
          cycle_cnt_d = '0;
          timed_out_d = 1'b0;
          mode_d      = mode;
        end
      end
      ST_RESET: begin
        if (abort) begin
          state_d     = ST_DONE;
          timed_out_d = 1'b0;
        end else if (rst_cnt_q == RST_LAST) begin
          state_d = mode_q ? ST_STEP : ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_RUN, ST_STEP: begin
        if (abort || halt_hit) begin
          state_d     = ST_DONE;
          timed_out_d = 1'b0;
        end else if (timeout_hit) begin
          state_d     = ST_DONE;
          timed_out_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    dp_rst_d = state_holds_dp_rst(state_d);
    busy_d   = state_is_busy(state_d);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      mode_q      <= 1'b0;
      dp_rst_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      mode_q      <= mode_d;
      dp_rst_q    <= dp_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign dp_rst    = dp_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timed_out = timed_out_q;
  assign cycle_cnt = cycle_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dp_run_controller.sv
// Bench for dp_run_controller: two configurations driven in lockstep, each with its
// own stand-in datapath PC, checked against a cycle-level behavioural model.
module tb_dp_run_controller;
  import dp_run_pkg::*;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic        step = 1'b0;
  logic [31:0] halt_addr = 32'h0;
  logic [31:0] pc0 = 32'h0;
  logic [31:0] pc1 = 32'h0;

  logic        dp_rst0, dp_en0, busy0, done0, timed_out0;
  logic [31:0] cycle_cnt0;
  run_state_e  dbg_state0;
  logic        dp_rst1, dp_en1, busy1, done1, timed_out1;
  logic [3:0]  cycle_cnt1;
  run_state_e  dbg_state1;

  dp_run_controller #(.RST_CYCLES(4), .ADDR_W(32), .CNT_W(32), .TIMEOUT(10)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .step(step),
    .halt_addr(halt_addr), .pc(pc0), .dp_rst(dp_rst0), .dp_en(dp_en0), .busy(busy0),
    .done(done0), .timed_out(timed_out0), .cycle_cnt(cycle_cnt0), .dbg_state(dbg_state0)
  );

  dp_run_controller #(.RST_CYCLES(2), .ADDR_W(32), .CNT_W(4), .TIMEOUT(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .step(step),
    .halt_addr(halt_addr), .pc(pc1), .dp_rst(dp_rst1), .dp_en(dp_en1), .busy(busy1),
    .done(done1), .timed_out(timed_out1), .cycle_cnt(cycle_cnt1), .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int P_IDLE  = 0;
  localparam int P_RESET = 1;
  localparam int P_RUN   = 2;
  localparam int P_STEP  = 3;
  localparam int P_DONE  = 4;

  int     k_rst[2] = '{4, 2};
  longint k_max[2] = '{64'hFFFF_FFFF, 15};
  int     k_to[2]  = '{10, 0};

  int     m_ph[2]    = '{P_IDLE, P_IDLE};
  int     m_rcnt[2]  = '{0, 0};
  longint m_cnt[2]   = '{0, 0};
  bit     m_mode[2]  = '{0, 0};
  bit     m_sprev[2] = '{0, 0};
  bit     m_tout[2]  = '{0, 0};

  function automatic bit model_en(input int i, input logic [31:0] pc);
    bit rise;
    rise = step && !m_sprev[i];
    return !rst && !abort && (pc != halt_addr) &&
           ((m_ph[i] == P_RUN) || ((m_ph[i] == P_STEP) && rise));
  endfunction

  task automatic model_advance(input int i, input bit en, input logic [31:0] pc);
    if (rst) begin
      m_ph[i] = P_IDLE; m_cnt[i] = 0; m_tout[i] = 0; m_mode[i] = 0; m_sprev[i] = 0;
      return;
    end
    m_sprev[i] = step;
    if (m_ph[i] == P_IDLE || m_ph[i] == P_DONE) begin
      if (start) begin
        m_ph[i] = P_RESET; m_rcnt[i] = 0; m_cnt[i] = 0; m_tout[i] = 0; m_mode[i] = mode;
      end
    end else if (m_ph[i] == P_RESET) begin
      if (abort) m_ph[i] = P_DONE;
      else if (m_rcnt[i] == k_rst[i] - 1) m_ph[i] = m_mode[i] ? P_STEP : P_RUN;
      else m_rcnt[i]++;
    end else begin
      if (abort || pc == halt_addr) begin
        m_ph[i] = P_DONE; m_tout[i] = 0;
      end else if (en) begin
        if (m_cnt[i] < k_max[i]) m_cnt[i]++;
        if (k_to[i] != 0 && m_cnt[i] == k_to[i]) begin
          m_ph[i] = P_DONE; m_tout[i] = 1;
        end
      end
    end
  endtask

  task automatic push_expected(input int i);
    exp_q.push_back({31'd0, m_ph[i] == P_IDLE || m_ph[i] == P_RESET});
    exp_q.push_back({31'd0, m_ph[i] == P_RESET || m_ph[i] == P_RUN || m_ph[i] == P_STEP});
    exp_q.push_back({31'd0, m_ph[i] == P_DONE});
    exp_q.push_back({31'd0, m_tout[i]});
    exp_q.push_back(32'(m_cnt[i]));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: combinational dp_en checked at negedge, registered outputs #1 after posedge.
  task automatic tick();
    bit en0, en1, rs0, rs1;
    @(negedge clk);
    en0 = model_en(0, pc0);
    en1 = model_en(1, pc1);
    check("dp_en0", {31'd0, dp_en0}, {31'd0, en0});
    check("dp_en1", {31'd0, dp_en1}, {31'd0, en1});
    rs0 = (m_ph[0] == P_IDLE || m_ph[0] == P_RESET);
    rs1 = (m_ph[1] == P_IDLE || m_ph[1] == P_RESET);
    model_advance(0, en0, pc0);
    model_advance(1, en1, pc1);
    push_expected(0);
    push_expected(1);
    @(posedge clk);
    #1;
    pc0 = rs0 ? 32'h0 : (en0 ? pc0 + 32'd4 : pc0);
    pc1 = rs1 ? 32'h0 : (en1 ? pc1 + 32'd4 : pc1);
    check("dp_rst0",    {31'd0, dp_rst0},    exp_q.pop_front());
    check("busy0",      {31'd0, busy0},      exp_q.pop_front());
    check("done0",      {31'd0, done0},      exp_q.pop_front());
    check("timed_out0", {31'd0, timed_out0}, exp_q.pop_front());
    check("cycle_cnt0", cycle_cnt0,          exp_q.pop_front());
    check("dp_rst1",    {31'd0, dp_rst1},    exp_q.pop_front());
    check("busy1",      {31'd0, busy1},      exp_q.pop_front());
    check("done1",      {31'd0, done1},      exp_q.pop_front());
    check("timed_out1", {31'd0, timed_out1}, exp_q.pop_front());
    check("cycle_cnt1", {28'd0, cycle_cnt1}, exp_q.pop_front());
  endtask

  task automatic start_run(input bit m, input logic [31:0] halt);
    mode = m; halt_addr = halt; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done0(input int bound);
    for (int k = 0; k < bound; k++) begin
      if (done0 === 1'b1) break;
      tick();
    end
    check("wait_done0", {31'd0, done0}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset
    rst = 1'b1;
    repeat (2) tick();
    check("rst_dp_rst", {31'd0, dp_rst0}, 32'd1);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_cnt", cycle_cnt0, 32'd0);
    rst = 1'b0;
    tick();

    // free run to halt at 0x20
    start_run(1'b0, 32'h20);
    wait_done0(40);
    check("halt_cnt", cycle_cnt0, 32'd8);
    check("halt_tout", {31'd0, timed_out0}, 32'd0);
    check("halt_pc", pc0, 32'h20);

    // timeout on dut0; dut1 runs on to saturation
    start_run(1'b0, 32'hFFFF_0000);
    wait_done0(40);
    check("to_cnt", cycle_cnt0, 32'd10);
    check("to_flag", {31'd0, timed_out0}, 32'd1);
    repeat (12) tick();
    check("sat_cnt1", {28'd0, cycle_cnt1}, 32'd15);
    check("sat_busy1", {31'd0, busy1}, 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;

    // halt coincides with the would-be timeout cycle
    start_run(1'b0, 32'h24);
    wait_done0(40);
    check("ho_cnt", cycle_cnt0, 32'd9);
    check("ho_tout", {31'd0, timed_out0}, 32'd0);

    // single-step: edge during RESET discarded, held step = one instruction
    start_run(1'b1, 32'hFFFF_0000);
    step = 1'b1; tick(); step = 1'b0;
    repeat (6) tick();
    check("step_none", cycle_cnt0, 32'd0);
    step = 1'b1; repeat (5) tick(); step = 1'b0; repeat (2) tick();
    check("step_one", cycle_cnt0, 32'd1);
    repeat (2) begin
      step = 1'b1; tick(); step = 1'b0; tick();
    end
    check("step_three", cycle_cnt0, 32'd3);
    check("step_busy", {31'd0, busy0}, 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;

    // abort after three run cycles, ignored start mid-run, restart from DONE
    start_run(1'b0, 32'hFFFF_0000);
    repeat (4) tick();
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_done", {31'd0, done0}, 32'd1);
    check("abort_cnt", cycle_cnt0, 32'd3);
    check("abort_busy", {31'd0, busy0}, 32'd0);
    start_run(1'b0, 32'hFFFF_0000);
    check("restart_busy", {31'd0, busy0}, 32'd1);
    check("restart_done", {31'd0, done0}, 32'd0);
    check("restart_cnt", cycle_cnt0, 32'd0);
    check("restart_dp_rst", {31'd0, dp_rst0}, 32'd1);

    // rst mid-run
    repeat (7) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_dp_rst", {31'd0, dp_rst0}, 32'd1);
    check("midrst_busy", {31'd0, busy0}, 32'd0);
    check("midrst_cnt", cycle_cnt0, 32'd0);
    tick();

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      abort = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 11) == 0);
      mode  = 1'($urandom_range(0, 1));
      step  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 29) == 0)
        halt_addr = ($urandom_range(0, 1) == 1) ? 32'(4 * $urandom_range(2, 14)) : 32'hFFFF_FFF0;
      tick();
    end
    rst = 1'b0; abort = 1'b0; start = 1'b0; step = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
